// File: rtl/div_share_pkg.sv
// Shared types and defaults for the divider-sharing controller.
package div_share_pkg;

    localparam int DIV_N       = 20;
    localparam int DIV_Q       = 15;
    localparam int DIV_NREQ    = 4;
    localparam int DIV_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_e;

    // Largest representable magnitude carrying the requested sign.
    function automatic logic [DIV_N-1:0] sat_value(input logic sign);
        sat_value = {sign, {(DIV_N-1){1'b1}}};
    endfunction

endpackage

// File: rtl/div_share_ctrl_rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   idx_s;
    logic            any_s;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        s = s - ((s >= NREQ) ? NREQ : 0);
        return IW'(s);
    endfunction

    // Scan from farthest to nearest offset so the nearest valid lane wins.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        any_s   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid_i[wrap_idx(ptr_i, i)]) begin
                idx_s = wrap_idx(ptr_i, i);
                any_s = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
        if (any_s) begin
            grant_s[idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign grant_o = grant_s;
    assign idx_o   = idx_s;
    assign any_o   = any_s;

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sign-magnitude fixed-point divider among NREQ requesters with
// round-robin arbitration, divide-by-zero bypass and a hung-divider watchdog.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int N       = DIV_N,
    parameter int Q       = DIV_Q,
    parameter int NREQ    = DIV_NREQ,
    parameter int TIMEOUT = DIV_TIMEOUT,
    localparam int IW = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*N-1:0] i_req_dividend,
    input  logic [NREQ*N-1:0] i_req_divisor,
    output logic              o_div_start,
    output logic [N-1:0]      o_div_dividend,
    output logic [N-1:0]      o_div_divisor,
    input  logic              i_div_complete,
    input  logic [N-1:0]      i_div_quotient,
    input  logic              i_div_overflow,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IW-1:0]     o_rsp_id,
    output logic [N-1:0]      o_rsp_quotient,
    output logic              o_rsp_overflow,
    output logic              o_rsp_dz,
    output logic              o_rsp_err
);

    // A limit below the divider's own nominal latency would kill healthy jobs,
    // so the effective limit is never allowed under that.
    localparam int WD_LIMIT = (TIMEOUT > N + Q + 4) ? TIMEOUT : N + Q + 5;
    localparam int WD_W     = $clog2(WD_LIMIT);

    div_state_e        state_q;
    logic [IW-1:0]     ptr_q;
    logic [WD_W-1:0]   wd_q;
    logic              used_q;
    logic [NREQ-1:0]   req_ready_q;
    logic              div_start_q;
    logic [N-1:0]      dividend_q;
    logic [N-1:0]      divisor_q;
    logic              rsp_valid_q;
    logic [IW-1:0]     rsp_id_q;
    logic [N-1:0]      rsp_quot_q;
    logic              rsp_ovf_q;
    logic              rsp_dz_q;
    logic              rsp_err_q;

    logic [NREQ-1:0]   pick_grant_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_any_s;
    logic [N-1:0]      sel_dividend_s;
    logic [N-1:0]      sel_divisor_s;
    logic [IW-1:0]     ptr_next_s;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    assign sel_dividend_s = i_req_dividend[int'(pick_idx_s)*N +: N];
    assign sel_divisor_s  = i_req_divisor[int'(pick_idx_s)*N +: N];
    assign ptr_next_s     = (pick_idx_s == IW'(NREQ - 1)) ? '0 : pick_idx_s + IW'(1);

    // Sequencer FSM with all handshake and response outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            wd_q        <= '0;
            used_q      <= 1'b0;
            req_ready_q <= '0;
            div_start_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quot_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_dz_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        req_ready_q <= pick_grant_s;
                        dividend_q  <= sel_dividend_s;
                        divisor_q   <= sel_divisor_s;
                        rsp_id_q    <= pick_idx_s;
                        ptr_q       <= ptr_next_s;
                        if (sel_divisor_s[N-2:0] == '0) begin
                            // Zero magnitude (either sign) never reaches the divider.
                            used_q      <= 1'b0;
                            rsp_quot_q  <= sat_value(sel_dividend_s[N-1] ^ sel_divisor_s[N-1]);
                            rsp_ovf_q   <= 1'b1;
                            rsp_dz_q    <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            used_q      <= 1'b1;
                            div_start_q <= 1'b1;
                            state_q     <= ST_START;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    wd_q    <= '0;
                    state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (i_div_complete) begin
                        rsp_quot_q  <= i_div_quotient;
                        rsp_ovf_q   <= i_div_overflow;
                        rsp_dz_q    <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                        rsp_quot_q  <= '0;
                        rsp_ovf_q   <= 1'b0;
                        rsp_dz_q    <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= used_q ? ST_DRAIN : ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    // Complete must be seen low so the next BUSY only sees fresh completions.
                    if (!i_div_complete) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready    = req_ready_q;
    assign o_div_start    = div_start_q;
    assign o_div_dividend = dividend_q;
    assign o_div_divisor  = divisor_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_id       = rsp_id_q;
    assign o_rsp_quotient = rsp_quot_q;
    assign o_rsp_overflow = rsp_ovf_q;
    assign o_rsp_dz       = rsp_dz_q;
    assign o_rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: scoreboard model of arbitration and
// fixed-point division, a behavioural divider, and per-cycle output checks.
module tb_div_share_ctrl;

    localparam int N = 20;
    localparam int Q = 15;
    localparam int NREQ = 4;
    localparam int TIMEOUT = 64;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ*N-1:0] i_req_dividend;
    logic [NREQ*N-1:0] i_req_divisor;
    logic              o_div_start;
    logic [N-1:0]      o_div_dividend;
    logic [N-1:0]      o_div_divisor;
    logic              i_div_complete;
    logic [N-1:0]      i_div_quotient;
    logic              i_div_overflow;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [IW-1:0]     o_rsp_id;
    logic [N-1:0]      o_rsp_quotient;
    logic              o_rsp_overflow;
    logic              o_rsp_dz;
    logic              o_rsp_err;

    div_share_ctrl #(.N(N), .Q(Q), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor),
        .o_div_start(o_div_start), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
        .i_div_complete(i_div_complete), .i_div_quotient(i_div_quotient), .i_div_overflow(i_div_overflow),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
        .o_rsp_quotient(o_rsp_quotient), .o_rsp_overflow(o_rsp_overflow),
        .o_rsp_dz(o_rsp_dz), .o_rsp_err(o_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct { int lane; logic [N-1:0] a; logic [N-1:0] b; } job_t;
    typedef struct { int id; logic [N-1:0] q; logic ovf; logic dz; logic err; logic used; } exp_t;

    int checks = 0;
    int errors = 0;
    job_t pend[$];
    exp_t sb[$];
    int grant_log[$];
    bit hang = 1'b0;
    int start_count = 0;
    logic [N-1:0] last_q;
    logic [IW-1:0] last_id;
    logic last_ovf, last_dz, last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference division: returns {overflow, quotient}; zero divisor and
    // out-of-range magnitudes saturate with the XOR sign.
    function automatic logic [N:0] div_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        logic s;
        longint unsigned ma, mb, m;
        s = a[N-1] ^ b[N-1];
        ma = longint'(a[N-2:0]);
        mb = longint'(b[N-2:0]);
        if (mb == 0) return {1'b1, s, {(N-1){1'b1}}};
        m = (ma << Q) / mb;
        if (m > longint'((1 << (N-1)) - 1)) return {1'b1, s, {(N-1){1'b1}}};
        return {1'b0, s, m[N-2:0]};
    endfunction

    // Requesters: present the oldest pending job per lane, retire it on ready.
    initial begin
        logic [NREQ-1:0] rs;
        i_req_valid = '0;
        i_req_dividend = '0;
        i_req_divisor = '0;
        forever begin
            @(negedge clk);
            rs = o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (rs[k]) begin
                    for (int j = 0; j < pend.size(); j++) begin
                        if (pend[j].lane == k) begin
                            pend.delete(j);
                            break;
                        end
                    end
                end
                i_req_valid[k] = 1'b0;
                for (int j = pend.size() - 1; j >= 0; j--) begin
                    if (pend[j].lane == k) begin
                        i_req_valid[k] = 1'b1;
                        i_req_dividend[k*N +: N] = pend[j].a;
                        i_req_divisor[k*N +: N] = pend[j].b;
                    end
                end
            end
        end
    end

    // Behavioural divider: fixed latency, complete held 1..3 cycles, or never.
    initial begin
        logic [N:0] r;
        int hold;
        hold = 1;
        i_div_complete = 1'b0;
        i_div_quotient = '0;
        i_div_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (o_div_start && !hang) begin
                r = div_ref(o_div_dividend, o_div_divisor);
                repeat (4) @(posedge clk);
                #1;
                i_div_complete = 1'b1;
                i_div_quotient = r[N-1:0];
                i_div_overflow = r[N];
                repeat (hold) @(posedge clk);
                #1;
                i_div_complete = 1'b0;
                hold = (hold % 3) + 1;
            end
        end
    end

    // Compare process: model arbitration and responses, check every cycle.
    int cyc = 0;
    bit rst_prev = 1'b0;
    bit outstanding = 1'b0;
    int mptr = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    bit cmpl_prev = 1'b0;
    bit rspv_prev = 1'b0;
    logic [NREQ-1:0] prev_valid = '0;

    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] eg;
        logic exp_start;
        logic [N-1:0] a, b;
        logic [N:0] r;
        exp_t e;
        cyc++;
        if (rst_prev) begin
            chk("reset_req_ready", o_req_ready, 0);
            chk("reset_div_start", o_div_start, 0);
            chk("reset_rsp_valid", o_rsp_valid, 0);
            chk("reset_rsp_fields", {o_rsp_id, o_rsp_quotient, o_rsp_overflow, o_rsp_dz, o_rsp_err}, 0);
            chk("reset_operands", {o_div_dividend, o_div_divisor}, 0);
            sb.delete();
            outstanding = 1'b0;
            mptr = 0;
        end else begin
            exp_start = 1'b0;
            if (o_req_ready != '0) begin
                chk("grant_while_busy", outstanding, 0);
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (w < 0 && prev_valid[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
                end
                eg = '0;
                if (w >= 0) eg[w] = 1'b1;
                chk("grant_lane", o_req_ready, eg);
                if (w >= 0) begin
                    a = i_req_dividend[w*N +: N];
                    b = i_req_divisor[w*N +: N];
                    chk("div_operands", {o_div_dividend, o_div_divisor}, {a, b});
                    r = div_ref(a, b);
                    e.id = w;
                    if (b[N-2:0] == '0) begin
                        e.q = r[N-1:0]; e.ovf = 1'b1; e.dz = 1'b1; e.err = 1'b0; e.used = 1'b0;
                        chk("dz_rsp_latency", o_rsp_valid, 1);
                    end else if (hang) begin
                        e.q = '0; e.ovf = 1'b0; e.dz = 1'b0; e.err = 1'b1; e.used = 1'b1;
                        exp_start = 1'b1;
                    end else begin
                        e.q = r[N-1:0]; e.ovf = r[N]; e.dz = 1'b0; e.err = 1'b0; e.used = 1'b1;
                        exp_start = 1'b1;
                    end
                    if (exp_start) start_cyc = cyc;
                    sb.push_back(e);
                    outstanding = 1'b1;
                    mptr = (w + 1) % NREQ;
                    grant_log.push_back(w);
                end
            end
            chk("div_start", o_div_start, exp_start);
            if (o_div_start) start_count++;
            if (o_rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", o_rsp_valid, 0);
                end else begin
                    e = sb[0];
                    chk("rsp_fields", {o_rsp_id, o_rsp_quotient, o_rsp_overflow, o_rsp_dz, o_rsp_err},
                        {2'(e.id), e.q, e.ovf, e.dz, e.err});
                    if (!rspv_prev && e.used && !e.err) chk("rsp_latency", cyc - rise_cyc, 1);
                    if (!rspv_prev && e.err)
                        chk("timeout_latency", (cyc - start_cyc == TIMEOUT) || (cyc - start_cyc == TIMEOUT + 1), 1);
                    if (i_rsp_ready) begin
                        last_q = o_rsp_quotient; last_id = o_rsp_id;
                        last_ovf = o_rsp_overflow; last_dz = o_rsp_dz; last_err = o_rsp_err;
                        sb.pop_front();
                        outstanding = 1'b0;
                    end
                end
            end
        end
        if (i_div_complete && !cmpl_prev) rise_cyc = cyc;
        cmpl_prev = i_div_complete;
        rspv_prev = o_rsp_valid;
        prev_valid = i_req_valid;
        rst_prev = i_rst;
    end

    task automatic wait_quiet(input int bound);
        int n;
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0 || o_rsp_valid) && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL wait_quiet: waited %0d cycles required below %0d", n, bound);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input logic [N-1:0] a, input logic [N-1:0] b);
        job_t j;
        j.lane = lane; j.a = a; j.b = b;
        pend.push_back(j);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int n, n0, sc;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        i_rst = 1'b1;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("model_pos", div_ref(20'h0C000, 20'h04000), {1'b0, 20'h18000});
        chk("model_neg", div_ref(20'h8C000, 20'h04000), {1'b0, 20'h98000});

        push(0, 20'h0C000, 20'h04000);
        wait_quiet(200);
        chk("t1_rsp", {last_id, last_q, last_ovf, last_dz, last_err}, {2'd0, 20'h18000, 3'b000});

        push(2, 20'h8C000, 20'h04000);
        wait_quiet(200);
        chk("t2_rsp", {last_id, last_q, last_ovf, last_dz, last_err}, {2'd2, 20'h98000, 3'b000});

        sc = start_count;
        push(1, 20'h0C000, 20'h80000);
        wait_quiet(200);
        chk("dz_rsp", {last_id, last_q, last_ovf, last_dz, last_err}, {2'd1, 20'hFFFFF, 3'b110});
        chk("dz_no_start", start_count, sc);

        do_reset();
        grant_log.delete();
        push(0, 20'h08000, 20'h08000);
        push(1, 20'h10000, 20'h04000);
        push(2, 20'h84000, 20'h08000);
        push(3, 20'h7FFFF, 20'h00001);
        push(0, 20'h02000, 20'h10000);
        wait_quiet(600);
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], rr_exp[i]);
        chk("rr_last_rsp", {last_id, last_q}, {2'd0, 20'h01000});

        i_rsp_ready = 1'b0;
        push(3, 20'h08000, 20'h08000);
        push(0, 20'h04000, 20'h08000);
        n = 0;
        while (!o_rsp_valid && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL stall_wait: no response within %0d cycles", n);
        end
        n0 = grant_log.size();
        repeat (10) @(posedge clk);
        chk("stall_rsp_held", o_rsp_valid, 1);
        chk("stall_no_grant", grant_log.size(), n0);
        #1;
        i_rsp_ready = 1'b1;
        wait_quiet(300);
        chk("stall_second_rsp", {last_id, last_q}, {2'd0, 20'h04000});

        hang = 1'b1;
        push(2, 20'h08000, 20'h08000);
        wait_quiet(300);
        chk("timeout_rsp", {last_id, last_q, last_ovf, last_dz, last_err}, {2'd2, 20'h00000, 3'b001});
        do_reset();

        push(1, 20'h08000, 20'h08000);
        n = 0;
        while (!o_div_start && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        hang = 1'b0;
        grant_log.delete();
        push(3, 20'h10000, 20'h08000);
        push(0, 20'h08000, 20'h10000);
        wait_quiet(300);
        chk("ptr_reset_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("ptr_reset_first", grant_log[0], 0);
            chk("ptr_reset_second", grant_log[1], 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
